// File: rtl/load_store_unit_if.sv
// Execute-side request/response bus and data-memory port of the load/store unit.
// The "slave" modport is the unit's side; "master" is the execute stage plus memory.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // resp_valid is a one-cycle pulse with no back-pressure; resp_rdata and
  // resp_error are meaningful only while it is high.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_error;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_write_ctrl;
  logic                  mem_read_ctrl;
  logic [DATA_WIDTH-1:0] mem_data_in;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr_out, mem_data_out, mem_write_ctrl, mem_read_ctrl
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr_out, mem_data_out, mem_write_ctrl, mem_read_ctrl
  );
endinterface

// File: rtl/load_store_unit.sv
// One-at-a-time load/store sequencer in front of a word-wide synchronous-read
// data memory; narrow stores are done as read-modify-write.
module load_store_unit #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int ADDR_WIDTH_POW = 6,
  parameter int WORD_BYTES_POW = 3
) (
  input  logic               clk_in,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [1:0]         state_dbg
);
  localparam int DATA_WIDTH = 1 << DATA_WIDTH_POW;
  localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;
  localparam int OFF_W      = WORD_BYTES_POW;
  localparam int SHIFT_W    = WORD_BYTES_POW + 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic                  write_q,  write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [OFF_W-1:0]      off_q,    off_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  error_q,  error_d;

  logic [OFF_W-1:0]      req_off;
  logic [OFF_W-1:0]      size_m1;
  logic [ADDR_WIDTH-1:0] req_aligned;
  logic                  req_bad;
  logic [SHIFT_W-1:0]    lane_shift;
  logic [DATA_WIDTH-1:0] field;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] size_ones;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged_word;

  // Legality of the request currently on the bus, evaluated only in IDLE.
  always_comb begin
    req_off     = bus.req_addr[OFF_W-1:0];
    req_aligned = {bus.req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    unique case (bus.req_funct3[1:0])
      2'd0:    size_m1 = '0;
      2'd1:    size_m1 = OFF_W'(1);
      2'd2:    size_m1 = OFF_W'(3);
      default: size_m1 = OFF_W'(7);
    endcase
    req_bad = (bus.req_funct3 == 3'b111) || (bus.req_write && bus.req_funct3[2]) ||
              (|(req_off & size_m1));
  end

  // Lane extraction for loads and byte-lane merge for narrow stores.
  always_comb begin
    lane_shift = {off_q, 3'b000};
    field      = bus.mem_data_in >> lane_shift;
    unique case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){field[7]}},   field[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){field[15]}}, field[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){field[31]}}, field[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},  field[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, field[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, field[31:0]};
      default: load_ext = field;
    endcase
    unique case (funct3_q[1:0])
      2'd0:    size_ones = DATA_WIDTH'(8'hFF);
      2'd1:    size_ones = DATA_WIDTH'(16'hFFFF);
      2'd2:    size_ones = DATA_WIDTH'(32'hFFFF_FFFF);
      default: size_ones = '1;
    endcase
    lane_mask   = size_ones << lane_shift;
    merged_word = (bus.mem_data_in & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          off_d    = req_off;
          addr_d   = req_aligned;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          error_d  = req_bad;
          if (req_bad) begin
            state_d = S_RESP;
          end else if (bus.req_write && bus.req_funct3[1:0] == 2'd3) begin
            // Full-word store needs no read of the old word.
            merged_d = bus.req_wdata;
            state_d  = S_WRITE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (write_q) begin
          merged_d = merged_word;
          state_d  = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Outputs are gated by reset so an aborted operation never writes or responds.
  always_comb begin
    bus.req_ready      = (state_q == S_IDLE) && !reset;
    bus.mem_read_ctrl  = !reset;
    bus.mem_write_ctrl = (state_q == S_WRITE) && !reset;
    bus.mem_data_out   = bus.mem_write_ctrl ? merged_q : '0;
    bus.resp_valid     = (state_q == S_RESP) && !reset;
    bus.resp_rdata     = bus.resp_valid ? rdata_q : '0;
    bus.resp_error     = bus.resp_valid && error_q;
    if (reset)                 bus.mem_addr_out = '0;
    else if (state_q == S_IDLE) bus.mem_addr_out = req_aligned;
    else                       bus.mem_addr_out = addr_q;
    state_dbg = state_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a word-array memory
// and an independent byte-level reference model of memory contents.
module tb_load_store_unit;
  logic clk;
  logic reset;
  logic [1:0] state_dbg;
  int n_cmp = 0;
  int n_err = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk_in    (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory (environment) ----------------
  logic [63:0] mem [0:63];
  logic [63:0] mem_rd;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem_rd <= '0;
    end else begin
      if (bus.mem_read_ctrl)  mem_rd <= mem[bus.mem_addr_out[8:3]];
      if (bus.mem_write_ctrl) mem[bus.mem_addr_out[8:3]] <= bus.mem_data_out;
    end
  end
  assign bus.mem_data_in = mem_rd;

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [0:511];

  function automatic void ref_clear();
    for (int i = 0; i < 512; i++) ref_bytes[i] = 8'h00;
  endfunction

  function automatic logic [63:0] ref_load(input logic [8:0] addr, input logic [2:0] f3);
    int nb;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_bytes[addr + 9'(k)];
    if (!f3[2] && nb < 8 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic void ref_store(input logic [8:0] addr, input logic [2:0] f3, input logic [63:0] wd);
    int nb;
    nb = 1 << f3[1:0];
    for (int k = 0; k < nb; k++) ref_bytes[addr + 9'(k)] = wd[8*k +: 8];
  endfunction

  function automatic logic [63:0] ref_word(input logic [8:0] addr);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ref_bytes[{addr[8:3], 3'b000} + 9'(k)];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd_out);
    logic        exp_err;
    int          exp_lat, nb, cyc, wr_cnt, wr_cyc, busy_ready;
    logic [63:0] exp_rdata, exp_wr_word, wr_addr, wr_data, got_rdata, got_err;
    logic        got_resp;

    nb        = 1 << f3[1:0];
    exp_err   = (f3 == 3'b111) || (w && f3[2]) || ((int'(addr[2:0]) % nb) != 0);
    exp_lat   = exp_err ? 1 : (!w ? 2 : (nb == 8 ? 2 : 3));
    exp_rdata = (exp_err || w) ? 64'd0 : ref_load(addr[8:0], f3);

    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    // Scramble the request fields: the unit must work from what it latched.
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_wdata  = {$urandom, $urandom};

    cyc = 0; wr_cnt = 0; wr_cyc = 0; busy_ready = 0; got_resp = 1'b0;
    wr_addr = '0; wr_data = '0; got_rdata = '0; got_err = '0;
    while (!got_resp && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready) busy_ready++;
      if (bus.mem_write_ctrl) begin
        wr_cnt++;
        wr_cyc  = cyc;
        wr_addr = bus.mem_addr_out;
        wr_data = bus.mem_data_out;
      end
      if (bus.resp_valid) begin
        got_resp  = 1'b1;
        got_rdata = bus.resp_rdata;
        got_err   = 64'(bus.resp_error);
      end
    end

    if (!w || exp_err) check("load_or_err_no_write", 64'(wr_cnt), 64'd0);
    if (!exp_err && w) begin
      ref_store(addr[8:0], f3, wd);
      exp_wr_word = ref_word(addr[8:0]);
      check("store_write_count", 64'(wr_cnt), 64'd1);
      check("store_write_cycle", 64'(wr_cyc), 64'(exp_lat - 1));
      check("store_write_addr", wr_addr, {55'd0, addr[8:3], 3'b000});
      check("store_write_data", wr_data, exp_wr_word);
    end
    check("resp_latency", got_resp ? 64'(cyc) : 64'd0, 64'(exp_lat));
    check("busy_ready_low", 64'(busy_ready), 64'd0);
    check("resp_error", got_err, 64'(exp_err));
    check("resp_rdata", got_rdata, exp_rdata);
    rd_out = got_rdata;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] rd;
  int quiet_resp;
  logic [2:0] rf3;
  logic [63:0] raddr;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    ref_clear();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid",  64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata",  bus.resp_rdata, 64'd0);
    check("rst_resp_error",  64'(bus.resp_error), 64'd0);
    check("rst_mem_write",   64'(bus.mem_write_ctrl), 64'd0);
    check("rst_mem_read",    64'(bus.mem_read_ctrl), 64'd0);
    check("rst_mem_addr",    bus.mem_addr_out, 64'd0);
    check("rst_mem_data",    bus.mem_data_out, 64'd0);
    check("rst_state",       64'(state_dbg), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready",  64'(bus.req_ready), 64'd1);
    check("post_rst_read",   64'(bus.mem_read_ctrl), 64'd1);

    // Directed sequence with literal expected values.
    run_op(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd);
    run_op(1'b0, 3'b011, 64'h10, 64'd0, rd);
    check("plan_ld_10", rd, 64'h1122334455667788);
    run_op(1'b1, 3'b000, 64'h13, 64'h00000000000000AB, rd);
    run_op(1'b0, 3'b011, 64'h10, 64'd0, rd);
    check("plan_ld_after_sb", rd, 64'h11223344AB667788);
    run_op(1'b0, 3'b000, 64'h13, 64'd0, rd);
    check("plan_lb", rd, 64'hFFFFFFFFFFFFFFAB);
    run_op(1'b0, 3'b100, 64'h13, 64'd0, rd);
    check("plan_lbu", rd, 64'h00000000000000AB);
    run_op(1'b1, 3'b010, 64'h14, 64'h0000000080000000, rd);
    run_op(1'b0, 3'b010, 64'h14, 64'd0, rd);
    check("plan_lw", rd, 64'hFFFFFFFF80000000);
    run_op(1'b0, 3'b110, 64'h14, 64'd0, rd);
    check("plan_lwu", rd, 64'h0000000080000000);
    run_op(1'b0, 3'b011, 64'h10, 64'd0, rd);
    check("plan_ld_after_sw", rd, 64'h80000000AB667788);

    // Error cases: latency, error flag and no write are checked inside run_op.
    run_op(1'b0, 3'b001, 64'h11, 64'd0, rd);
    run_op(1'b1, 3'b010, 64'h12, 64'hDEAD, rd);
    run_op(1'b0, 3'b011, 64'h0C, 64'd0, rd);
    run_op(1'b1, 3'b100, 64'h10, 64'hFF, rd);
    run_op(1'b0, 3'b111, 64'h10, 64'd0, rd);

    // Reset asserted during the WRITE cycle of an SH.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 64'h10;
    bus.req_wdata  = 64'hBEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sh_in_write", 64'(bus.mem_write_ctrl), 64'd1);
    reset = 1'b1;
    #1;
    check("sh_write_suppressed", 64'(bus.mem_write_ctrl), 64'd0);
    check("sh_no_resp_in_reset", 64'(bus.resp_valid), 64'd0);
    ref_clear();
    @(negedge clk);
    reset = 1'b0;
    quiet_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) quiet_resp++;
    end
    check("aborted_no_resp", 64'(quiet_resp), 64'd0);
    run_op(1'b0, 3'b011, 64'h10, 64'd0, rd);
    check("plan_ld_after_reset", rd, 64'd0);

    // Restore known data, then back-to-back LD/LB with req_valid held high.
    run_op(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h10;
    @(posedge clk);
    #1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 64'h17;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", c), 64'(bus.req_ready), 64'(c == 3));
      check($sformatf("b2b_valid_c%0d", c), 64'(bus.resp_valid), 64'(c == 2 || c == 5));
      if (c == 2) check("b2b_ld_data", bus.resp_rdata, 64'h1122334455667788);
      if (c == 5) check("b2b_lb_data", bus.resp_rdata, 64'h0000000000000011);
      if (c == 4) bus.req_valid = 1'b0;
    end

    // Randomized traffic against the byte-level model.
    for (int n = 0; n < 200; n++) begin
      rf3   = 3'($urandom_range(0, 7));
      raddr = 64'($urandom_range(0, 504));
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~64'((1 << rf3[1:0]) - 1);
      run_op(1'($urandom_range(0, 1)), rf3, raddr, {$urandom, $urandom}, rd);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
